// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: load funct3 codes and the load-queue entry layout.
package wb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_funct3_e;

  // funct3 is kept raw so that unlisted codes survive to the formatter and fall back to a word load
  typedef struct packed {
    logic            live;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [1:0]      off;
    logic [XLEN-1:0] word;
  } ld_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks the byte/half at the access offset and sign/zero extends it.
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);
  import wb_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  // Misaligned halves are trapped upstream, so off[0] is ignored for LH/LHU
  always_comb begin
    result = word;
    case (funct3)
      LD_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
      LD_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU results and queued load responses onto the single register-file write port.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_word,
  output logic            write_enable,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     ld_pending
);
  import wb_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ld_entry_t       q [DEPTH];
  ld_entry_t       head_e;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            alu_write, enq, pop, head_write;
  logic [XLEN-1:0] head_data;

  assign head_e    = q[head];
  assign ld_ready  = count < CW'(DEPTH);
  assign alu_write = alu_valid && (alu_rd != 5'd0);
  // A same-cycle ALU write to the same rd is the younger instruction, so that load is dropped
  assign enq       = ld_valid && ld_ready && (ld_rd != 5'd0) && !(alu_write && (alu_rd == ld_rd));
  assign pop       = (count != '0) && (!alu_write || !head_e.live);
  assign head_write = pop && head_e.live && !alu_write;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3 (head_e.funct3),
    .off    (head_e.off),
    .word   (head_e.word),
    .result (head_data)
  );

  // Popped and killed entries have live cleared, so live alone marks an outstanding destination
  always_comb begin
    ld_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].live) ld_pending[q[i].rd] = 1'b1;
    end
    ld_pending[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_write && (q[i].rd == alu_rd)) q[i].live <= 1'b0;
      end
      if (pop) begin
        q[head].live <= 1'b0;
        head         <= head + PW'(1);
      end
      if (enq) begin
        q[tail] <= '{live: 1'b1, rd: ld_rd, funct3: ld_funct3, off: ld_off, word: ld_word};
        tail    <= tail + PW'(1);
      end
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // The ALU always owns the port; a load only writes in a cycle the ALU leaves free
      if (alu_write) begin
        write_enable <= 1'b1;
        write_addr   <= alu_rd;
        write_data   <= alu_data;
      end else if (head_write) begin
        write_enable <= 1'b1;
        write_addr   <= head_e.rd;
        write_data   <= head_data;
      end else begin
        write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected writes, a negedge monitor pops and compares.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [31:0] ld_word;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] ld_pending;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  localparam logic [31:0] AW = 32'h80FF7F01;

  wb_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_funct3    (ld_funct3),
    .ld_off       (ld_off),
    .ld_word      (ld_word),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .ld_pending   (ld_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    sb.push_back(w);
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the next rising edge
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                               input logic [1:0] off, input logic [31:0] word);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adata;
    ld_valid  = lv;
    ld_rd     = lrd;
    ld_funct3 = f3;
    ld_off    = off;
    ld_word   = word;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wr_t w;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got x%0d=0x%08h expected no write", write_addr, write_data);
      end else begin
        w = sb.pop_front();
        if (write_addr !== w.addr || write_data !== w.data) begin
          errors++;
          $display("[TB] FAIL write: got x%0d=0x%08h expected x%0d=0x%08h",
                   write_addr, write_data, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle(3);
    checkOutput("reset_we", {31'd0, write_enable}, 32'd0);
    checkOutput("reset_addr", {27'd0, write_addr}, 32'd0);
    checkOutput("reset_data", write_data, 32'd0);
    checkOutput("reset_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("reset_pending", ld_pending, 32'd0);
    reset = 1'b0;
    idle(1);

    // ALU only; rd=0 must not write
    expectWrite(5'd5, 32'h00001234);
    applyStimulus(1'b1, 5'd5, 32'h00001234, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    idle(2);

    // Alignment of 0x80FF7F01, including an unlisted funct3 and a discarded rd=0 load
    expectWrite(5'd10, 32'hFFFFFF80);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 3'b000, 2'd3, AW);
    expectWrite(5'd11, 32'h00000001);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 3'b100, 2'd0, AW);
    expectWrite(5'd12, 32'hFFFF80FF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 3'b001, 2'd2, AW);
    expectWrite(5'd13, 32'h000080FF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 3'b101, 2'd2, AW);
    expectWrite(5'd14, 32'h80FF7F01);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 3'b010, 2'd0, AW);
    expectWrite(5'd15, 32'h80FF7F01);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 3'b011, 2'd1, AW);
    expectWrite(5'd16, 32'h0000007F);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 3'b100, 2'd1, AW);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 3'b010, 2'd0, AW);
    idle(3);
    checkOutput("align_pending_idle", ld_pending, 32'd0);

    // Collision: ALU x3 wins, load x7 follows
    expectWrite(5'd3, 32'h00000033);
    expectWrite(5'd7, 32'h00000077);
    applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b1, 5'd7, 3'b010, 2'd0, 32'h00000077);
    checkOutput("collide_pending7", {31'd0, ld_pending[7]}, 32'd1);
    idle(1);
    checkOutput("collide_pending7_clear", {31'd0, ld_pending[7]}, 32'd0);
    idle(2);

    // Full queue under continuous ALU writes
    checkOutput("full_ready_c0", {31'd0, ld_ready}, 32'd1);
    expectWrite(5'd20, 32'h00000020);
    applyStimulus(1'b1, 5'd20, 32'h00000020, 1'b1, 5'd1, 3'b010, 2'd0, 32'h00000101);
    checkOutput("full_ready_c1", {31'd0, ld_ready}, 32'd1);
    expectWrite(5'd21, 32'h00000021);
    applyStimulus(1'b1, 5'd21, 32'h00000021, 1'b1, 5'd2, 3'b010, 2'd0, 32'h00000202);
    checkOutput("full_ready_c2", {31'd0, ld_ready}, 32'd0);
    checkOutput("full_pending", ld_pending, 32'h00000006);
    expectWrite(5'd22, 32'h00000022);
    applyStimulus(1'b1, 5'd22, 32'h00000022, 1'b1, 5'd4, 3'b010, 2'd0, 32'h00000404);
    checkOutput("full_ready_c3", {31'd0, ld_ready}, 32'd0);
    expectWrite(5'd23, 32'h00000023);
    applyStimulus(1'b1, 5'd23, 32'h00000023, 1'b1, 5'd4, 3'b010, 2'd0, 32'h00000404);
    checkOutput("full_ready_pop", {31'd0, ld_ready}, 32'd0);
    expectWrite(5'd1, 32'h00000101);
    expectWrite(5'd2, 32'h00000202);
    expectWrite(5'd4, 32'h00000404);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 3'b010, 2'd0, 32'h00000404);
    checkOutput("full_ready_after_pop", {31'd0, ld_ready}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 3'b010, 2'd0, 32'h00000404);
    idle(4);

    // WAW kill of a queued load, and same-cycle discard
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 3'b010, 2'd0, 32'h00000999);
    checkOutput("waw_pending9_set", {31'd0, ld_pending[9]}, 32'd1);
    expectWrite(5'd9, 32'h0000000A);
    applyStimulus(1'b1, 5'd9, 32'h0000000A, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    checkOutput("waw_pending9_clear", {31'd0, ld_pending[9]}, 32'd0);
    idle(2);
    expectWrite(5'd11, 32'h000000BB);
    applyStimulus(1'b1, 5'd11, 32'h000000BB, 1'b1, 5'd11, 3'b010, 2'd0, 32'h00000CCC);
    checkOutput("waw_same_cycle_pending", ld_pending, 32'd0);
    idle(3);

    // Reset with two queued loads
    expectWrite(5'd25, 32'h00000025);
    applyStimulus(1'b1, 5'd25, 32'h00000025, 1'b1, 5'd12, 3'b010, 2'd0, 32'h00000E12);
    expectWrite(5'd26, 32'h00000026);
    applyStimulus(1'b1, 5'd26, 32'h00000026, 1'b1, 5'd13, 3'b010, 2'd0, 32'h00000E13);
    checkOutput("rst_pre_pending", ld_pending, 32'h00003000);
    reset = 1'b1;
    idle(1);
    checkOutput("rst_mid_we", {31'd0, write_enable}, 32'd0);
    checkOutput("rst_mid_addr", {27'd0, write_addr}, 32'd0);
    checkOutput("rst_mid_data", write_data, 32'd0);
    checkOutput("rst_mid_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("rst_mid_pending", ld_pending, 32'd0);
    reset = 1'b0;
    idle(6);

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
